// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (read-only) and load/store requesters.
// Data wins by default; a starvation counter eventually forces a fetch grant.
module mem_port_arbiter #(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DWIDTH-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DWIDTH-1:0] d_rdata_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_IF,
        RESP_D
    } resp_e;

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    resp_e         resp_state_q, resp_state_d;
    logic          fetch_win;

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt_q <= '0;
            resp_state_q <= RESP_NONE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            resp_state_q <= resp_state_d;
        end
    end

    always_comb begin
        fetch_win      = if_req_i && (!d_req_i || starve_cnt_q >= LIMIT);
        if_gnt_o       = rst && fetch_win;
        d_gnt_o        = rst && d_req_i && !fetch_win;
        mem_addr_o     = '0;
        mem_data_o     = '0;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        resp_state_d   = RESP_NONE;
        starve_cnt_d   = starve_cnt_q;

        if (if_gnt_o) begin
            mem_addr_o    = if_addr_i;
            mem_read_en_o = 1'b1;
            resp_state_d  = RESP_IF;
        end else if (d_gnt_o) begin
            mem_addr_o = d_addr_i;
            if (d_we_i) begin
                mem_write_en_o = 1'b1;
                mem_data_o     = d_wdata_i;
            end else begin
                mem_read_en_o = 1'b1;
                resp_state_d  = RESP_D;
            end
        end

        // Saturating count of consecutive denied fetch cycles
        if (!if_req_i || if_gnt_o) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q < LIMIT) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_comb begin
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        d_rvalid_o  = 1'b0;
        d_rdata_o   = '0;
        if (rst) begin
            unique case (resp_state_q)
                RESP_IF: begin
                    if_rvalid_o = 1'b1;
                    if_rdata_o  = mem_data_i;
                end
                RESP_D: begin
                    d_rvalid_o = 1'b1;
                    d_rdata_o  = mem_data_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, reads, writes,
// starvation rotation, back-to-back responses and reset mid-read.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_read_en_o;
    logic        mem_write_en_o;
    logic [31:0] mem_data_i;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AWIDTH(32),
        .DWIDTH(32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_i      (if_req_i),
        .if_addr_i     (if_addr_i),
        .if_gnt_o      (if_gnt_o),
        .if_rvalid_o   (if_rvalid_o),
        .if_rdata_o    (if_rdata_o),
        .d_req_i       (d_req_i),
        .d_we_i        (d_we_i),
        .d_addr_i      (d_addr_i),
        .d_wdata_i     (d_wdata_i),
        .d_gnt_o       (d_gnt_o),
        .d_rvalid_o    (d_rvalid_o),
        .d_rdata_o     (d_rdata_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_read_en_o (mem_read_en_o),
        .mem_write_en_o(mem_write_en_o),
        .mem_data_i    (mem_data_i)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; checks happen mid-cycle.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        rst        = 1'b0;
        if_req_i   = 1'b1;
        if_addr_i  = 32'h0100_0000;
        d_req_i    = 1'b1;
        d_we_i     = 1'b0;
        d_addr_i   = 32'h0100_0010;
        d_wdata_i  = 32'h1234_5678;
        mem_data_i = 32'hFFFF_FFFF;

        for (int i = 0; i < 3; i++) begin
            next_cyc();
            settle();
            chk("rst_gnt", {if_gnt_o, d_gnt_o}, 2'b00);
            chk("rst_rvalid", {if_rvalid_o, d_rvalid_o}, 2'b00);
            chk("rst_en", {mem_read_en_o, mem_write_en_o}, 2'b00);
            chk("rst_addr", mem_addr_o, 32'h0);
            chk("rst_rdata", {if_rdata_o, d_rdata_o}, 64'h0);
        end

        // Fetch read after reset release
        next_cyc();
        rst     = 1'b1;
        d_req_i = 1'b0;
        settle();
        chk("if_gnt", if_gnt_o, 1'b1);
        chk("if_rd_en", mem_read_en_o, 1'b1);
        chk("if_addr", mem_addr_o, 32'h0100_0000);

        next_cyc();
        if_req_i   = 1'b0;
        mem_data_i = 32'hA5A5_0001;
        settle();
        chk("if_rvalid", if_rvalid_o, 1'b1);
        chk("if_rdata", if_rdata_o, 32'hA5A5_0001);
        chk("if_d_rvalid", d_rvalid_o, 1'b0);
        chk("if_d_rdata", d_rdata_o, 32'h0);

        // Data read
        next_cyc();
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_addr_i = 32'h0100_0010;
        settle();
        chk("d_gnt", {if_gnt_o, d_gnt_o}, 2'b01);
        chk("d_rd_en", {mem_read_en_o, mem_write_en_o}, 2'b10);
        chk("d_addr", mem_addr_o, 32'h0100_0010);

        next_cyc();
        d_req_i    = 1'b0;
        mem_data_i = 32'h5A5A_0002;
        settle();
        chk("d_rvalid", {if_rvalid_o, d_rvalid_o}, 2'b01);
        chk("d_rdata", d_rdata_o, 32'h5A5A_0002);
        chk("d_if_rdata", if_rdata_o, 32'h0);

        // Data write
        next_cyc();
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h0100_0020;
        d_wdata_i = 32'hDEAD_BEEF;
        settle();
        chk("wr_gnt", d_gnt_o, 1'b1);
        chk("wr_en", {mem_read_en_o, mem_write_en_o}, 2'b01);
        chk("wr_data", mem_data_o, 32'hDEAD_BEEF);
        chk("wr_addr", mem_addr_o, 32'h0100_0020);

        next_cyc();
        d_req_i = 1'b0;
        d_we_i  = 1'b0;
        settle();
        chk("wr_no_rvalid", {if_rvalid_o, d_rvalid_o}, 2'b00);
        chk("idle_en", {mem_read_en_o, mem_write_en_o}, 2'b00);
        chk("idle_addr", mem_addr_o, 32'h0);

        // Starvation: fetch wins every fifth cycle
        next_cyc();
        if_req_i  = 1'b1;
        d_req_i   = 1'b1;
        d_we_i    = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) next_cyc();
            settle();
            chk($sformatf("stv_gnt%0d", k), {if_gnt_o, d_gnt_o},
                (k % 5 == 4) ? 2'b10 : 2'b01);
            if (k > 0) begin
                chk($sformatf("stv_rv%0d", k), {if_rvalid_o, d_rvalid_o},
                    ((k - 1) % 5 == 4) ? 2'b10 : 2'b01);
            end
        end

        next_cyc();
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
        settle();
        chk("stv_last_rv", {if_rvalid_o, d_rvalid_o}, 2'b10);

        // Back-to-back fetch then data read
        next_cyc();
        if_req_i  = 1'b1;
        if_addr_i = 32'h0100_0040;
        settle();
        chk("b2b_if_gnt", {if_gnt_o, d_gnt_o}, 2'b10);

        next_cyc();
        if_req_i   = 1'b0;
        d_req_i    = 1'b1;
        d_addr_i   = 32'h0100_0050;
        mem_data_i = 32'h1111_2222;
        settle();
        chk("b2b_d_gnt", {if_gnt_o, d_gnt_o}, 2'b01);
        chk("b2b_if_rv", {if_rvalid_o, d_rvalid_o}, 2'b10);
        chk("b2b_if_rd", if_rdata_o, 32'h1111_2222);
        chk("b2b_addr", mem_addr_o, 32'h0100_0050);

        next_cyc();
        d_req_i    = 1'b0;
        mem_data_i = 32'h3333_4444;
        settle();
        chk("b2b_d_rv", {if_rvalid_o, d_rvalid_o}, 2'b01);
        chk("b2b_d_rd", d_rdata_o, 32'h3333_4444);

        // Reset arriving while a fetch read is outstanding
        next_cyc();
        if_req_i = 1'b1;
        settle();
        chk("mid_gnt", if_gnt_o, 1'b1);

        next_cyc();
        if_req_i = 1'b0;
        rst      = 1'b0;
        settle();
        chk("mid_rv1", {if_rvalid_o, d_rvalid_o}, 2'b00);
        chk("mid_rd1", if_rdata_o, 32'h0);

        next_cyc();
        rst = 1'b1;
        settle();
        chk("mid_rv2", {if_rvalid_o, d_rvalid_o}, 2'b00);

        next_cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data memory between the fetch stage (read-only requester) and the load/store stage (read/write requester).
- Arbitrates one access per cycle: data priority by default, with a starvation guard that forces a fetch grant.
- Tracks the one-cycle read latency and steers returned data to the requester that issued the read.
- Sits between fetch/memory-stage logic and the memory module, driving its addr/data/read_en/write_en pins.

Parameters:
- AWIDTH, 32, address width
- DWIDTH, 32, data width
- STARVE_LIMIT, 4, consecutive denied fetch-request cycles after which fetch takes priority (>=1)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-low reset (rst==0 resets on posedge clk)
- if_req_i  input  1  fetch read request
- if_addr_i  input  AWIDTH  fetch address
- if_gnt_o  output  1  fetch request accepted this cycle
- if_rvalid_o  output  1  fetch read data valid
- if_rdata_o  output  DWIDTH  fetch read data
- d_req_i  input  1  data request
- d_we_i  input  1  1=write, 0=read
- d_addr_i  input  AWIDTH  data address
- d_wdata_i  input  DWIDTH  write data
- d_gnt_o  output  1  data request accepted this cycle
- d_rvalid_o  output  1  data read data valid
- d_rdata_o  output  DWIDTH  data read data
- mem_addr_o  output  AWIDTH  memory address
- mem_data_o  output  DWIDTH  memory write data
- mem_read_en_o  output  1  memory read enable
- mem_write_en_o  output  1  memory write enable
- mem_data_i  input  DWIDTH  memory read data, valid the cycle after mem_read_en_o

Behaviour:
- Reset (rst==0 at posedge): starve_cnt=0; resp_state=RESP_NONE. While rst==0, all grant, rvalid, and mem enable outputs are forced to 0, and mem_addr_o/mem_data_o/rdata outputs are forced to 0.
- Reset mid-operation: any read granted in the cycle before reset returns no response; rvalid stays 0.
- Grants are combinational from the current-cycle requests. At most one of if_gnt_o/d_gnt_o is high per cycle.
  - Only one requester active: that requester is granted.
  - Both active, starve_cnt < STARVE_LIMIT: data granted.
  - Both active, starve_cnt >= STARVE_LIMIT: fetch granted.
- Requesters hold req/addr/wdata stable until their gnt is seen. A grant completes the handshake in that cycle.
- Memory drive in the grant cycle:
  - mem_addr_o = granted address.
  - mem_read_en_o = 1 for a fetch grant or a data read grant.
  - mem_write_en_o = 1 only for a data write grant; mem_data_o = d_wdata_i then.
  - With no grant: both enables 0, mem_addr_o=0, mem_data_o=0.
- starve_cnt (registered, saturates at STARVE_LIMIT):
  - Increments when if_req_i==1 and if_gnt_o==0.
  - Clears to 0 on if_gnt_o or when if_req_i==0.
- Response FSM (resp_state register, updated each cycle):
  - Next state is RESP_IF after a fetch grant, RESP_D after a data read grant, RESP_NONE otherwise (including data write grants).
  - In RESP_IF: if_rvalid_o=1, if_rdata_o=mem_data_i.
  - In RESP_D: d_rvalid_o=1, d_rdata_o=mem_data_i.
  - The non-selected rdata output is driven to 0.
- Latency and throughput:
  - Read data returns exactly 1 cycle after the grant.
  - Back-to-back grants every cycle are allowed; a response and a new grant coexist in the same cycle.
  - Writes complete in the grant cycle and produce no rvalid.
- Address and data are passed through unmodified; there is no width conversion.

Test Plan:
- Reset: hold rst=0 for 3 cycles with both requests high -> all gnt/rvalid/enables 0; after release with only if_req_i=1, if_addr_i=0x01000000 -> if_gnt_o=1, mem_read_en_o=1, mem_addr_o=0x01000000; next cycle if_rvalid_o=1, if_rdata_o=mem_data_i.
- Data read: d_req_i=1, d_we_i=0, d_addr_i=0x01000010 -> d_gnt_o=1; next cycle d_rvalid_o=1, if_rvalid_o=0.
- Data write: d_we_i=1, d_wdata_i=0xDEADBEEF, d_addr_i=0x01000020 -> mem_write_en_o=1, mem_read_en_o=0, mem_data_o=0xDEADBEEF; next cycle no rvalid.
- Starvation (STARVE_LIMIT=4): both requests held high continuously -> d_gnt_o for cycles 0-3, if_gnt_o in cycle 4, d_gnt_o in cycle 5; the pattern repeats with period 5.
- Back-to-back: fetch grant in cycle N, data read grant in cycle N+1 -> if_rvalid_o in N+1, d_rvalid_o in N+2, each with its own mem_data_i value.
- Reset mid-read: fetch granted in cycle N, rst=0 in cycle N+1 -> if_rvalid_o=0 in N+1 and N+2.
